// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Round-robin arbiter sharing the single ARF write port between result
// producers (0 = ALU, 1 = LSU, 2 = MDU by default). The winner is registered
// into a one-entry write-back stage. Stall freezes the stage, flush kills it,
// writes to x0 are suppressed, and a saturating counter tracks the cycles in
// which two or more producers compete.
module wb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_we,
  input  logic [NUM_REQ-1:0][4:0]         i_req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic                            i_flush,
  input  logic                            i_stall,
  output logic                            o_wb_en,
  output logic [4:0]                      o_wb_rd,
  output logic [XLEN-1:0]                 o_wb_data,
  output logic [$clog2(NUM_REQ)-1:0]      o_wb_src,
  output logic [CNT_W-1:0]                o_conflict_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             valid_q, valid_d;
  logic             we_q, we_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_vld_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic             accept_s;
  logic [NUM_REQ-1:0] ready_s;
  logic             multi_s;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx_v;
    grant_vld_s = 1'b0;
    grant_idx_s = {SRC_W{1'b0}};
    idx_v       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = int'(rr_ptr_q) + i;
      if (idx_v >= NUM_REQ) begin
        idx_v = idx_v - NUM_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (!grant_vld_s && i_req_valid[idx_v]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = SRC_W'(idx_v);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign accept_s = grant_vld_s && !i_stall && !i_flush;

  // One-hot ready to the granted requester only; forced low while in reset.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if (accept_s && rst_n) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Detect two or more simultaneous valid requests.
  always_comb begin
    int pop_v;
    pop_v = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_v = pop_v + int'(i_req_valid[i]);
    end
    multi_s = (pop_v >= 2);
  end

  // Next state of the write-back stage and priority pointer; flush beats stall.
  always_comb begin
    valid_d  = valid_q;
    we_d     = we_q;
    rd_d     = rd_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_stall) begin
      valid_d = valid_q;
    end else if (grant_vld_s) begin
      valid_d = 1'b1;
      we_d    = i_req_we[grant_idx_s];
      rd_d    = i_req_rd[grant_idx_s];
      data_d  = i_req_data[grant_idx_s];
      src_d   = grant_idx_s;
      if (grant_idx_s == SRC_W'(NUM_REQ - 1)) begin
        rr_ptr_d = {SRC_W{1'b0}};
      end else begin
        rr_ptr_d = grant_idx_s + SRC_W'(1);
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Saturating contention counter, counted regardless of stall or flush.
  always_comb begin
    if (multi_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= {SRC_W{1'b0}};
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= {XLEN{1'b0}};
      src_q    <= {SRC_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_req_ready    = ready_s;
  assign o_wb_en        = valid_q && we_q && (rd_q != 5'd0) && !i_flush;
  assign o_wb_rd        = rd_q;
  assign o_wb_data      = data_q;
  assign o_wb_src       = src_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter: a default 3-requester instance and
// a 2-requester instance with a 4-bit counter for saturation.
module tb_wb_port_arbiter;

  logic              clk;
  logic              rst_n;
  logic [2:0]        req_valid;
  logic [2:0]        req_we;
  logic [2:0][4:0]   req_rd;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic              flush;
  logic              stall;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [1:0]        wb_src;
  logic [15:0]       cnt;

  logic [1:0]        b_valid;
  logic [1:0]        b_we;
  logic [1:0][4:0]   b_rd;
  logic [1:0][31:0]  b_data;
  logic [1:0]        b_ready;
  logic              b_wb_en;
  logic [4:0]        b_wb_rd;
  logic [31:0]       b_wb_data;
  logic [0:0]        b_wb_src;
  logic [3:0]        b_cnt;

  int n_checks;
  int n_errors;

  wb_port_arbiter #(.NUM_REQ(3), .XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_rd(req_rd), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_flush(flush), .i_stall(stall),
    .o_wb_en(wb_en), .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_wb_src(wb_src),
    .o_conflict_cnt(cnt)
  );

  wb_port_arbiter #(.NUM_REQ(2), .XLEN(32), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(b_valid), .i_req_we(b_we), .i_req_rd(b_rd), .i_req_data(b_data),
    .o_req_ready(b_ready), .i_flush(1'b0), .i_stall(1'b0),
    .o_wb_en(b_wb_en), .o_wb_rd(b_wb_rd), .o_wb_data(b_wb_data), .o_wb_src(b_wb_src),
    .o_conflict_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 3'b000; req_we = 3'b000; req_rd = '0; req_data = '0;
    flush = 1'b0; stall = 1'b0;
    b_valid = 2'b00; b_we = 2'b00; b_rd = '0; b_data = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    check("rst_wb_en",   64'(wb_en),     64'd0);
    check("rst_wb_rd",   64'(wb_rd),     64'd0);
    check("rst_wb_data", 64'(wb_data),   64'd0);
    check("rst_cnt",     64'(cnt),       64'd0);
    check("rst_ready",   64'(req_ready), 64'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Single source: ALU writes x5.
    req_valid = 3'b001; req_we = 3'b001; req_rd[0] = 5'd5; req_data[0] = 32'h1234;
    #1;
    check("single_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    check("single_en",   64'(wb_en),   64'd1);
    check("single_rd",   64'(wb_rd),   64'd5);
    check("single_data", 64'(wb_data), 64'h1234);
    check("single_src",  64'(wb_src),  64'd0);
    tick();
    check("single_idle_en", 64'(wb_en), 64'd0);

    // Round-robin with all three valid for 6 cycles.
    do_reset();
    clear_inputs();
    req_valid = 3'b111; req_we = 3'b111;
    for (int i = 0; i < 3; i++) begin
      req_rd[i]   = 5'(i + 1);
      req_data[i] = 32'h100 + 32'(i);
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      if (k == 5) req_valid = 3'b000;
      check("rr_rd",   64'(wb_rd),   64'((k % 3) + 1));
      check("rr_src",  64'(wb_src),  64'(k % 3));
      check("rr_data", 64'(wb_data), 64'(32'h100 + 32'(k % 3)));
    end
    check("rr_cnt", 64'(cnt), 64'd6);

    // Stall holds the stage and blocks acceptance.
    do_reset();
    clear_inputs();
    req_valid = 3'b010; req_we = 3'b011; req_rd[1] = 5'd7; req_data[1] = 32'hCAFE;
    #1;
    check("stall_lsu_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b001; req_rd[0] = 5'd3; req_data[0] = 32'h55;
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_en",    64'(wb_en),     64'd1);
      check("stall_rd",    64'(wb_rd),     64'd7);
      check("stall_data",  64'(wb_data),   64'hCAFE);
      check("stall_ready", 64'(req_ready), 64'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    check("unstall_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    check("unstall_rd",  64'(wb_rd),  64'd3);
    check("unstall_src", 64'(wb_src), 64'd0);
    check("unstall_en",  64'(wb_en),  64'd1);

    // Flush kills the held entry and blocks the MDU.
    do_reset();
    clear_inputs();
    req_valid = 3'b001; req_we = 3'b101; req_rd[0] = 5'd9; req_data[0] = 32'h99;
    req_rd[2] = 5'd10; req_data[2] = 32'hAA;
    tick();
    req_valid = 3'b100;
    check("preflush_en", 64'(wb_en), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_en",    64'(wb_en),     64'd0);
    check("flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("postflush_en",    64'(wb_en),     64'd0);
    check("postflush_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b000;
    check("mdu_en",  64'(wb_en),  64'd1);
    check("mdu_rd",  64'(wb_rd),  64'd10);
    check("mdu_src", 64'(wb_src), 64'd2);

    // x0 target and we=0 are accepted but never write.
    do_reset();
    clear_inputs();
    req_valid = 3'b011; req_we = 3'b001; req_rd[0] = 5'd0; req_rd[1] = 5'd4;
    req_data[0] = 32'h11; req_data[1] = 32'h22;
    #1;
    check("x0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b010;
    check("x0_en",  64'(wb_en),  64'd0);
    check("x0_src", 64'(wb_src), 64'd0);
    #1;
    check("we0_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    check("we0_en",  64'(wb_en),  64'd0);
    check("we0_src", 64'(wb_src), 64'd1);
    check("we0_rd",  64'(wb_rd),  64'd4);
    req_valid = 3'b101;
    #1;
    check("ptr_past_ready", 64'(req_ready), 64'b100);
    req_valid = 3'b000;

    // Saturation on the 4-bit counter instance.
    do_reset();
    clear_inputs();
    b_valid = 2'b11; b_we = 2'b11; b_rd[0] = 5'd1; b_rd[1] = 5'd2;
    for (int c = 0; c < 14; c++) tick();
    check("sat_cnt14", 64'(b_cnt), 64'd14);
    for (int c = 0; c < 6; c++) tick();
    check("sat_cnt20", 64'(b_cnt), 64'd15);

    // Asynchronous reset mid-stream.
    req_valid = 3'b111; req_we = 3'b111; req_rd[0] = 5'd6; req_data[0] = 32'hBEEF;
    tick();
    check("pre_rst_en", 64'(wb_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en",    64'(wb_en),     64'd0);
    check("mid_rst_rd",    64'(wb_rd),     64'd0);
    check("mid_rst_data",  64'(wb_data),   64'd0);
    check("mid_rst_src",   64'(wb_src),    64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_cnt",   64'(cnt),       64'd0);
    check("mid_rst_bcnt",  64'(b_cnt),     64'd0);
    check("mid_rst_bready",64'(b_ready),   64'd0);
    clear_inputs();
    #3;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
